despread: RTL and testbench

- Receive-side counterpart of the DSSS spreader: the despreader.
- Accepts a chip stream, XORs each chip with the same pseudo-random spreading code, and majority-votes every SPREAD chips into one recovered data bit.
- Also reports the chip-error count per symbol.
- Sits after chip recovery and before the bit sink. Instantiates its own lfsr (same module and seed as the transmit side) so the codes match bit-exactly.

---
 rtl/despread.sv | 138 +++++++++++++
 tb/tb_despread.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/despread.sv
// DSSS despreader: XORs received chips with a locally generated spreading code
// and majority-votes each group of SPREAD chips into one data bit.

module lfsr #(
    parameter logic [6:0] SEED = 7'h5A
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_valid,
    output logic o_data
);
    logic [6:0] state_reg;

    // x^7 + x^6 + 1, Fibonacci form; must match the spreader's instance exactly
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg <= SEED;
        end else if (i_valid) begin
            state_reg <= {state_reg[5:0], state_reg[6] ^ state_reg[5]};
        end
    end

    assign o_data = state_reg[6];
endmodule

module despread #(
    parameter int SPREAD       = 24,
    parameter int SIZE_COUNTER = $clog2(SPREAD),
    parameter int SIZE_ACC     = $clog2(SPREAD + 1)
) (
    input  logic                i_clk,
    input  logic                i_reset,
    output logic                o_ready,
    input  logic                i_start,
    input  logic                i_data,
    input  logic                i_valid,
    output logic                o_data,
    output logic                o_valid,
    output logic [SIZE_ACC-1:0] o_errors
);
    localparam logic [SIZE_COUNTER-1:0] LAST = SIZE_COUNTER'(SPREAD - 1);
    localparam logic [SIZE_ACC-1:0]     HALF = SIZE_ACC'(SPREAD / 2);
    localparam logic [SIZE_ACC-1:0]     FULL = SIZE_ACC'(SPREAD);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state_reg, state_next;
    logic [SPREAD-1:0]       code_reg;
    logic [SIZE_COUNTER-1:0] counter_reg;
    logic [SIZE_ACC-1:0]     acc_reg;
    logic                    lfsr_en_reg;
    logic                    ready_reg;
    logic                    data_reg;
    logic                    valid_reg;
    logic [SIZE_ACC-1:0]     errors_reg;
    logic                    lfsr_bit;

    logic                    chip_v;
    logic                    accept;
    logic [SIZE_ACC-1:0]     total;
    logic                    vote;

    lfsr u_lfsr (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_valid (lfsr_en_reg),
        .o_data  (lfsr_bit)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg <= ST_LOAD;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (state_reg == ST_LOAD && counter_reg == LAST) begin
            state_next = ST_RUN;
        end
    end

    assign chip_v = i_data ^ code_reg[counter_reg];
    assign accept = ready_reg & i_valid;
    assign total  = acc_reg + SIZE_ACC'(chip_v);
    // Ties resolve to 0 since the comparison is strict
    assign vote   = (total > HALF);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            code_reg    <= '0;
            counter_reg <= '0;
            acc_reg     <= '0;
            lfsr_en_reg <= 1'b1;
            ready_reg   <= 1'b0;
            data_reg    <= 1'b0;
            valid_reg   <= 1'b0;
            errors_reg  <= '0;
        end else begin
            valid_reg <= 1'b0;
            if (state_reg == ST_LOAD) begin
                // The chip counter doubles as the load index; the last code bit stays 0
                if (counter_reg != LAST) begin
                    code_reg[counter_reg] <= lfsr_bit;
                    counter_reg           <= counter_reg + SIZE_COUNTER'(1);
                end else begin
                    counter_reg <= '0;
                    lfsr_en_reg <= 1'b0;
                    ready_reg   <= 1'b1;
                end
            end else if (ready_reg && i_start) begin
                acc_reg     <= i_valid ? SIZE_ACC'(chip_v) : '0;
                counter_reg <= i_valid ? SIZE_COUNTER'(1) : '0;
            end else if (accept) begin
                if (counter_reg == LAST) begin
                    data_reg    <= vote;
                    errors_reg  <= vote ? (FULL - total) : total;
                    valid_reg   <= 1'b1;
                    counter_reg <= '0;
                    acc_reg     <= '0;
                end else begin
                    acc_reg     <= total;
                    counter_reg <= counter_reg + SIZE_COUNTER'(1);
                end
            end
        end
    end

    assign o_ready  = ready_reg;
    assign o_data   = data_reg;
    assign o_valid  = valid_reg;
    assign o_errors = errors_reg;
endmodule

// File: tb/tb_despread.sv
// Scoreboard bench for despread: a spreader model drives chips and queues the
// expected symbol results; a monitor pops and compares on every o_valid.

module tb_despread;
    localparam int SPREAD = 24;

    typedef struct {
        logic d;
        int   e;
        int   cyc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic       din;
    logic       vin;
    logic       ready;
    logic       dout;
    logic       vout;
    logic [4:0] errors;

    exp_t        exp_q[$];
    logic [23:0] code;
    int          cyc;
    int          n_cmp;
    int          n_bad;
    int          n_push;
    int          n_pulse;

    despread #(.SPREAD(SPREAD)) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .o_ready  (ready),
        .i_start  (start),
        .i_data   (din),
        .i_valid  (vin),
        .o_data   (dout),
        .o_valid  (vout),
        .o_errors (errors)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        n_cmp = n_cmp + 1;
        if (act != expv) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Transmit-side code: same polynomial and seed as the spreader
    task automatic build_code();
        logic [6:0] s;
        s = 7'h5A;
        for (int k = 0; k < SPREAD - 1; k++) begin
            code[k] = s[6];
            s = {s[5:0], s[6] ^ s[5]};
        end
        code[SPREAD-1] = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (vout) begin
            n_pulse = n_pulse + 1;
            if (exp_q.size() == 0) begin
                check("unexpected_o_valid", 1, 0);
            end else begin
                x = exp_q.pop_front();
                $display("symbol: o_data=%0d o_errors=%0d (expect %0d/%0d) cycle %0d",
                         dout, errors, x.d, x.e, cyc);
                check("o_data", int'(dout), int'(x.d));
                check("o_errors", int'(errors), x.e);
                check("latency", cyc, x.cyc);
            end
        end
    end

    // Sends n chips of bit b (flipped where flips is set), starting at a negedge
    task automatic send_sym(input logic b, input logic [23:0] flips, input int n,
                            input logic st, input int maxgap,
                            input logic exp_d, input int exp_e);
        exp_t x;
        for (int k = 0; k < n; k++) begin
            din   = b ^ code[k] ^ flips[k];
            vin   = 1'b1;
            start = (k == 0) ? st : 1'b0;
            if (k == SPREAD - 1) begin
                x.d = exp_d;
                x.e = exp_e;
                x.cyc = cyc + 1;
                exp_q.push_back(x);
                n_push = n_push + 1;
            end
            @(negedge clk);
            vin   = 1'b0;
            start = 1'b0;
            if (maxgap > 0) repeat ($urandom_range(0, maxgap)) @(negedge clk);
        end
    endtask

    task automatic wait_load();
        int edges;
        edges = 0;
        check("ready_at_release", int'(ready), 0);
        while (ready !== 1'b1 && edges < 40) begin
            @(posedge clk);
            #1;
            edges = edges + 1;
        end
        check("load_cycles", edges, 24);
        @(negedge clk);
    endtask

    initial begin
        logic b;
        n_cmp = 0; n_bad = 0; n_push = 0; n_pulse = 0;
        rst = 1'b1; start = 1'b0; din = 1'b0; vin = 1'b0;
        build_code();
        repeat (3) @(negedge clk);
        check("rst_ready", int'(ready), 0);
        check("rst_valid", int'(vout), 0);
        check("rst_data", int'(dout), 0);
        check("rst_errors", int'(errors), 0);
        rst = 1'b0;
        wait_load();
        repeat (10) @(negedge clk);

        // Clean loopback, contiguous chips
        send_sym(1'b1, 24'h0, 24, 1'b0, 0, 1'b1, 0);
        send_sym(1'b0, 24'h0, 24, 1'b0, 0, 1'b0, 0);
        send_sym(1'b1, 24'h0, 24, 1'b0, 0, 1'b1, 0);
        send_sym(1'b1, 24'h0, 24, 1'b0, 0, 1'b1, 0);

        // Chip errors: 5, 11, and a 12/12 tie
        send_sym(1'b1, 24'h408488, 24, 1'b0, 0, 1'b1, 5);
        send_sym(1'b1, 24'h0007FF, 24, 1'b0, 0, 1'b1, 11);
        send_sym(1'b1, 24'h000FFF, 24, 1'b0, 0, 1'b0, 12);

        // Random bits with random gaps
        for (int i = 0; i < 8; i++) begin
            b = 1'($urandom_range(0, 1));
            send_sym(b, 24'h0, 24, 1'b0, 5, b, 0);
        end

        // Partial symbol discarded by i_start carrying chip 0
        send_sym(1'b1, 24'h0, 10, 1'b0, 0, 1'b0, 0);
        send_sym(1'b0, 24'h0, 24, 1'b1, 0, 1'b0, 0);

        send_sym(1'b1, 24'h408488, 24, 1'b0, 0, 1'b1, 5);
        repeat (3) @(negedge clk);

        // Reset mid-symbol
        send_sym(1'b0, 24'h0, 12, 1'b0, 0, 1'b0, 0);
        rst = 1'b1;
        #1;
        check("midrst_ready", int'(ready), 0);
        check("midrst_valid", int'(vout), 0);
        check("midrst_data", int'(dout), 0);
        check("midrst_errors", int'(errors), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_load();
        send_sym(1'b0, 24'h000111, 24, 1'b0, 0, 1'b0, 3);
        send_sym(1'b1, 24'h0, 24, 1'b0, 2, 1'b1, 0);

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("pulse_count", n_pulse, n_push);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
